tcp_state_store_mp: RTL

//  Parametrised per-flow TCP state memory for the receive pipe: one write port, RD_PORTS_P

---
 rtl/tcp_pkg.sv | 20 ++
 rtl/tcp_state_rd_port.sv | 53 +++++
 rtl/tcp_state_store_mp.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tcp_pkg.sv
// Shared definitions for the receive-pipe TCP per-flow state store.
//   TCP_STATE_W   : bits in one per-flow TCP state record
//   MAX_FLOW_CNT  : number of flows tracked (one record each)
//   FLOWID_W      : width of a flow ID
//   tcp_state_t   : one state record
//   store_state_e : store controller state (init sweep, then serving)
package tcp_pkg;

    localparam int TCP_STATE_W  = 32;
    localparam int MAX_FLOW_CNT = 16;
    localparam int FLOWID_W     = $clog2(MAX_FLOW_CNT);

    typedef logic [TCP_STATE_W-1:0] tcp_state_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } store_state_e;

endpackage

// File: rtl/tcp_state_rd_port.sv
// One read port of the TCP state store: single-entry response register with
// valid/ready handshakes on both request and response sides.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : store is out of its init sweep and may accept requests
//   req_val     : read request valid
//   req_addr    : flow ID to read
//   rd_data     : record for req_addr this cycle (already forwarded/ranged by the top)
//   req_rdy     : request accepted when req_val & req_rdy
//   resp_val    : response register holds a record
//   resp_addr   : flow ID of the held record
//   resp_data   : held record (snapshot taken when the request was accepted)
//   resp_rdy    : consumer takes the held response
module tcp_state_rd_port #(
    parameter int WIDTH_P = 32,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               req_val,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [WIDTH_P-1:0] rd_data,
    output logic               req_rdy,
    output logic               resp_val,
    output logic [ADDR_W-1:0]  resp_addr,
    output logic [WIDTH_P-1:0] resp_data,
    input  logic               resp_rdy
);

    logic req_fire;

    // The register can take a new request when it is empty or being drained
    // this cycle, which gives one response per cycle back-to-back.
    assign req_rdy  = enable & (~resp_val | resp_rdy);
    assign req_fire = req_val & req_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_val  <= 1'b0;
            resp_addr <= '0;
            resp_data <= '0;
        end else if (req_fire) begin
            resp_val  <= 1'b1;
            resp_addr <= req_addr;
            resp_data <= rd_data;
        end else if (resp_rdy) begin
            resp_val  <= 1'b0;
        end
    end

endmodule

// File: rtl/tcp_state_store_mp.sv
// Per-flow TCP state memory: one write port, RD_PORTS_P independent read ports.
// After reset every record is swept to INIT_VAL_P (ELS_P cycles), then the store
// serves traffic until the next reset. A read and a write to the same flow in the
// same cycle return the written record.
//   clk, rst_n     : clock, asynchronous active-low reset
//   init_done      : init sweep finished, store is serving
//   wr_req_*       : write request (val/addr/data), wr_req_rdy high once serving
//   rd_req_*       : per-port read request (val/addr), rd_req_rdy per port
//   rd_resp_*      : per-port response (val/addr/data), rd_resp_rdy per port
module tcp_state_store_mp
    import tcp_pkg::*;
#(
    parameter int                 WIDTH_P    = TCP_STATE_W,
    parameter int                 ELS_P      = MAX_FLOW_CNT,
    parameter int                 RD_PORTS_P = 2,
    parameter logic [WIDTH_P-1:0] INIT_VAL_P = '0,
    localparam int                ADDR_W     = $clog2(ELS_P)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic                                  init_done,
    input  logic                                  wr_req_val,
    input  logic [ADDR_W-1:0]                     wr_req_addr,
    input  logic [WIDTH_P-1:0]                    wr_req_data,
    output logic                                  wr_req_rdy,
    input  logic [RD_PORTS_P-1:0]                 rd_req_val,
    input  logic [RD_PORTS_P-1:0][ADDR_W-1:0]     rd_req_addr,
    output logic [RD_PORTS_P-1:0]                 rd_req_rdy,
    output logic [RD_PORTS_P-1:0]                 rd_resp_val,
    output logic [RD_PORTS_P-1:0][ADDR_W-1:0]     rd_resp_addr,
    output logic [RD_PORTS_P-1:0][WIDTH_P-1:0]    rd_resp_data,
    input  logic [RD_PORTS_P-1:0]                 rd_resp_rdy
);

    // Flow IDs at or above ELS_P only exist when ELS_P is not a power of two.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (ELS_P == (1 << ADDR_W)) || (int'(a) < ELS_P);
    endfunction

    store_state_e      state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              ready;
    logic              wr_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH_P-1:0] mem_wdata;

    logic [WIDTH_P-1:0]                 mem [ELS_P];
    logic [RD_PORTS_P-1:0][WIDTH_P-1:0] rd_data;

    assign ready      = (state_q == ST_READY);
    assign init_done  = ready;
    assign wr_req_rdy = ready;
    assign wr_fire    = wr_req_val & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // The sweep and normal writes share the single array write port.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a value unassigned (which would infer a latch).
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_req_addr;
        mem_wdata  = wr_req_data;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr_q;
                mem_wdata = INIT_VAL_P;
                if (init_ptr_q == ADDR_W'(ELS_P - 1)) begin
                    state_d = ST_READY;
                end else begin
                    init_ptr_d = init_ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                mem_we = wr_fire & addr_ok(wr_req_addr);
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: the storage array has no reset; the init sweep gives it defined
    // contents, and leaving it reset-free lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < RD_PORTS_P; p++) begin : g_rd_port
        // Write-first: a same-cycle write to the same flow wins over the array.
        assign rd_data[p] = !addr_ok(rd_req_addr[p])                        ? INIT_VAL_P  :
                            (wr_fire && (wr_req_addr == rd_req_addr[p]))   ? wr_req_data :
                                                                             mem[rd_req_addr[p]];

        tcp_state_rd_port #(
            .WIDTH_P (WIDTH_P),
            .ADDR_W  (ADDR_W)
        ) u_rd_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (ready),
            .req_val   (rd_req_val[p]),
            .req_addr  (rd_req_addr[p]),
            .rd_data   (rd_data[p]),
            .req_rdy   (rd_req_rdy[p]),
            .resp_val  (rd_resp_val[p]),
            .resp_addr (rd_resp_addr[p]),
            .resp_data (rd_resp_data[p]),
            .resp_rdy  (rd_resp_rdy[p])
        );

        rd_addr_range_a: assert property (@(posedge clk) disable iff (!rst_n)
            (rd_req_val[p] && rd_req_rdy[p]) |-> addr_ok(rd_req_addr[p]));
    end

    wr_addr_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        wr_fire |-> addr_ok(wr_req_addr));

endmodule
